// File: rtl/wb_write_queue_pkg.sv
// Shared CPU constants and the register write-back request bundle.
package cpu_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_write_queue_match.sv
// Youngest-match search over age-ordered queue entries.
// Index 0 is the oldest entry, so later hits overwrite earlier ones.
module wb_match
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic [AW-1:0]             iQAddr,
  input  logic [DEPTH-1:0]          iValid,
  input  logic [DEPTH-1:0][AW-1:0]  iAddr,
  input  logic [DEPTH-1:0][DW-1:0]  iData,
  output logic                      oHit,
  output logic [DW-1:0]             oData
);

  always_comb begin
    oHit  = 1'b0;
    oData = '0;
    if (iQAddr != AW'(REG_ZERO)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (iValid[i] && (iAddr[i] == iQAddr)) begin
          oHit  = 1'b1;
          oData = iData[i];
        end
      end
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// Register-file write-back queue: two producers, one drain port,
// and a two-port bypass lookup of the newest pending value.
module wb_write_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iValid0,
  input  logic [AW-1:0] iAddr0,
  input  logic [DW-1:0] iData0,
  output logic          oReady0,
  input  logic          iValid1,
  input  logic [AW-1:0] iAddr1,
  input  logic [DW-1:0] iData1,
  output logic          oReady1,
  input  logic          iDrainEn,
  output logic          oWena,
  output logic [AW-1:0] oWAddr,
  output logic [DW-1:0] oWData,
  input  logic [AW-1:0] iQAddr1,
  input  logic [AW-1:0] iQAddr2,
  output logic          oQHit1,
  output logic          oQHit2,
  output logic [DW-1:0] oQData1,
  output logic [DW-1:0] oQData2,
  output logic [CW-1:0] oCount
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DW-1:0] data_q, data_d;

  logic [CW-1:0] free;
  logic          fire0, fire1;
  logic          push0, push1;
  logic [PW-1:0] slot1;

  logic [DEPTH-1:0]         age_valid;
  logic [DEPTH-1:0][AW-1:0] age_addr;
  logic [DEPTH-1:0][DW-1:0] age_data;

  // A same-cycle pop does not free space for a push.
  assign free    = CW'(DEPTH) - count_q;
  assign oReady0 = (free >= CW'(1));
  assign oReady1 = (free >= CW'(2)) ||
                   ((free == CW'(1)) && !iValid0);

  assign fire0 = iValid0 && oReady0;
  assign fire1 = iValid1 && oReady1;
  assign push0 = fire0 && (iAddr0 != AW'(REG_ZERO));
  assign push1 = fire1 && (iAddr1 != AW'(REG_ZERO));
  assign slot1 = tail_q + PW'(push0);

  assign oWena  = (count_q != '0) && iDrainEn;
  assign oWAddr = (count_q != '0) ? addr_q[head_q] : '0;
  assign oWData = (count_q != '0) ? data_q[head_q] : '0;
  assign oCount = count_q;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q + PW'(push0) + PW'(push1);
    count_d = count_q + CW'(push0) + CW'(push1) - CW'(oWena);
    if (push0) begin
      addr_d[tail_q] = iAddr0;
      data_d[tail_q] = iData0;
    end
    if (push1) begin
      addr_d[slot1] = iAddr1;
      data_d[slot1] = iData1;
    end
    if (oWena) begin
      head_d = head_q + PW'(1);
    end
  end

  always_comb begin
    age_valid = '0;
    age_addr  = '0;
    age_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_valid[i] = (CW'(i) < count_q);
      age_addr[i]  = addr_q[head_q + PW'(i)];
      age_data[i]  = data_q[head_q + PW'(i)];
    end
  end

  wb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match1 (
    .iQAddr (iQAddr1),
    .iValid (age_valid),
    .iAddr  (age_addr),
    .iData  (age_data),
    .oHit   (oQHit1),
    .oData  (oQData1)
  );

  wb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match2 (
    .iQAddr (iQAddr2),
    .iValid (age_valid),
    .iAddr  (age_addr),
    .iData  (age_data),
    .oHit   (oQHit2),
    .oData  (oQData2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    (CW'(push0) + CW'(push1)) <= free
  );

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed and random checks of wb_write_queue against a queue model.
module tb_wb_write_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW = REG_AW;
  localparam int DW = REG_DW;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          iValid0, iValid1, iDrainEn;
  logic [AW-1:0] iAddr0, iAddr1, iQAddr1, iQAddr2;
  logic [DW-1:0] iData0, iData1;
  logic          oReady0, oReady1, oWena;
  logic [AW-1:0] oWAddr;
  logic [DW-1:0] oWData, oQData1, oQData2;
  logic          oQHit1, oQHit2;
  logic [CW-1:0] oCount;

  int vectors = 0;
  int miscompares = 0;
  bit known = 1'b0;
  wb_req_t q[$];

  wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .iValid0(iValid0), .iAddr0(iAddr0), .iData0(iData0),
    .oReady0(oReady0),
    .iValid1(iValid1), .iAddr1(iAddr1), .iData1(iData1),
    .oReady1(oReady1),
    .iDrainEn(iDrainEn),
    .oWena(oWena), .oWAddr(oWAddr), .oWData(oWData),
    .iQAddr1(iQAddr1), .iQAddr2(iQAddr2),
    .oQHit1(oQHit1), .oQHit2(oQHit2),
    .oQData1(oQData1), .oQData2(oQData2),
    .oCount(oCount)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Newest pending value: scan from the youngest end backwards.
  function automatic void lookup(input logic [AW-1:0] a,
                                 output bit hit,
                                 output logic [DW-1:0] d);
    hit = 1'b0;
    d = '0;
    if (a != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].addr == a) begin
          hit = 1'b1;
          d = q[i].data;
          break;
        end
      end
    end
  endfunction

  task automatic drive(bit v0, int a0, int d0,
                       bit v1, int a1, int d1, bit dr);
    iValid0 = v0; iAddr0 = AW'(a0); iData0 = DW'(d0);
    iValid1 = v1; iAddr1 = AW'(a1); iData1 = DW'(d1);
    iDrainEn = dr;
  endtask

  // One clock: check outputs against the model, then advance it.
  task automatic step();
    int cnt, fr;
    bit r0, r1, we, h1, h2, f0, f1, rs;
    logic [DW-1:0] d1, d2;
    wb_req_t c0, c1;
    #1;
    cnt = q.size();
    fr = DEPTH - cnt;
    r0 = fr >= 1;
    r1 = (fr >= 2) || (fr == 1 && !iValid0);
    we = (cnt != 0) && iDrainEn;
    lookup(iQAddr1, h1, d1);
    lookup(iQAddr2, h2, d2);
    if (known) begin
      chk("ready0", 64'(oReady0), 64'(r0));
      chk("ready1", 64'(oReady1), 64'(r1));
      chk("wena", 64'(oWena), 64'(we));
      chk("waddr", 64'(oWAddr), cnt != 0 ? 64'(q[0].addr) : 64'd0);
      chk("wdata", 64'(oWData), cnt != 0 ? 64'(q[0].data) : 64'd0);
      chk("count", 64'(oCount), 64'(cnt));
      chk("qhit1", 64'(oQHit1), 64'(h1));
      chk("qdata1", 64'(oQData1), 64'(d1));
      chk("qhit2", 64'(oQHit2), 64'(h2));
      chk("qdata2", 64'(oQData2), 64'(d2));
    end
    f0 = iValid0 && r0;
    f1 = iValid1 && r1;
    c0 = '{addr: iAddr0, data: iData0};
    c1 = '{addr: iAddr1, data: iData1};
    rs = rst;
    @(posedge clk);
    if (rs) begin
      q.delete();
    end else begin
      if (we) void'(q.pop_front());
      if (f0 && c0.addr != 0) q.push_back(c0);
      if (f1 && c1.addr != 0) q.push_back(c1);
    end
    known = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    iQAddr1 = '0; iQAddr2 = '0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step();
    rst = 1'b0;
    #1;
    chk("rst_count", 64'(oCount), 64'd0);
    chk("rst_wena", 64'(oWena), 64'd0);
    chk("rst_wdata", 64'(oWData), 64'd0);
    chk("rst_ready0", 64'(oReady0), 64'd1);
    chk("rst_ready1", 64'(oReady1), 64'd1);
    chk("rst_qhit1", 64'(oQHit1), 64'd0);

    // Single write, visible to the register file the next cycle.
    drive(1, 5, 'h1234, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("single_wena", 64'(oWena), 64'd1);
    chk("single_waddr", 64'(oWAddr), 64'd5);
    chk("single_wdata", 64'(oWData), 64'h1234);
    step();
    chk("single_empty", 64'(oCount), 64'd0);

    // Both channels to reg 3; ch1 is younger.
    drive(1, 3, 'hA, 1, 3, 'hB, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    iQAddr1 = 5'd3;
    #1;
    chk("dual_count", 64'(oCount), 64'd2);
    chk("dual_hit", 64'(oQHit1), 64'd1);
    chk("dual_data", 64'(oQData1), 64'hB);
    iDrainEn = 1'b1;
    #1;
    chk("dual_first", 64'(oWData), 64'hA);
    step();
    chk("dual_second", 64'(oWData), 64'hB);
    step();
    iQAddr1 = '0;

    // Fill to capacity with no drain.
    for (int k = 1; k <= 3; k++) begin
      drive(1, k, k * 'h100, 0, 0, 0, 0);
      step();
    end
    drive(1, 4, 'h400, 1, 9, 'h900, 0);
    #1;
    chk("cnt3_ready1_v0", 64'(oReady1), 64'd0);
    iValid0 = 1'b0;
    #1;
    chk("cnt3_ready1_nov0", 64'(oReady1), 64'd1);
    iValid0 = 1'b1;
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("full_ready0", 64'(oReady0), 64'd0);
    chk("full_ready1", 64'(oReady1), 64'd0);
    chk("full_count", 64'(oCount), 64'd4);
    iDrainEn = 1'b1;
    for (int k = 0; k < 4; k++) step();

    // Continuous push/drain wraps head and tail.
    for (int k = 1; k <= 10; k++) begin
      drive(1, k, k * 'h11, 0, 0, 0, 1);
      step();
      chk("wrap_count_le1", 64'(oCount <= 1), 64'd1);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    step();

    // Writes to x0 are swallowed.
    drive(0, 0, 0, 1, 0, 'hFFFF, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    iQAddr1 = '0;
    #1;
    chk("zero_count", 64'(oCount), 64'd0);
    chk("zero_wena", 64'(oWena), 64'd0);
    chk("zero_qhit", 64'(oQHit1), 64'd0);
    step();

    // Reset with three pending writes discards them.
    for (int k = 0; k < 3; k++) begin
      drive(1, 20 + k, 'hC0 + k, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    iDrainEn = 1'b1;
    #1;
    chk("midrst_count", 64'(oCount), 64'd0);
    chk("midrst_wena", 64'(oWena), 64'd0);
    for (int k = 0; k < 3; k++) step();

    // Random traffic, occasional reset.
    for (int n = 0; n < 500; n++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
            $urandom_range(0, 2) != 0);
      iQAddr1 = AW'($urandom_range(0, 7));
      iQAddr2 = AW'($urandom_range(0, 7));
      rst = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
